dmem_stream_reader: RTL and testbench

//  Host-side reader for the RV32 data memory: drains a word region
//  (e.g. WOS filter output) as a valid/ready stream. Initiator on the

---
 rtl/dmem_rd_pkg.sv | 19 +
 rtl/dmem_rd_fifo.sv | 63 ++++++
 rtl/dmem_stream_reader.sv | 178 +++++++++++++++++
 tb/tb_dmem_stream_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_rd_pkg.sv
// Shared types for the data-memory stream reader: FSM states, word size and
// the output-buffer entry layout.
package dmem_rd_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } rd_entry_t;

endpackage

// File: rtl/dmem_rd_fifo.sv
// Small synchronous FIFO holding read words (with their last tag) between the
// memory port and the output stream. Head is presented directly from storage.
module dmem_rd_fifo
    import dmem_rd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  rd_entry_t                    i_data,
    input  logic                         i_pop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output rd_entry_t                    o_head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rd_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/dmem_stream_reader.sv
// Drains a word region of the data memory as a valid/ready stream through a
// granted, 1-cycle-latency read port. Optional running sum: DMEM_RD_CHECKSUM_EN.
module dmem_stream_reader
    import dmem_rd_pkg::*;
#(
    parameter int MEM_SIZE   = 1024,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [31:0]      i_base,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mem_rd_en,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_gnt,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_tvalid,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    input  logic             i_tready
`ifdef DMEM_RD_CHECKSUM_EN
    ,
    output logic [31:0]      o_sum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e        r_state;
    rd_state_e        w_state_nxt;
    logic [31:0]      r_addr;
    logic [31:0]      w_addr_inc;
    logic [31:0]      w_addr_nxt;
    logic [31:0]      w_occupancy;
    logic [LEN_W-1:0] r_issue_cnt;
    logic [LEN_W-1:0] r_emit_cnt;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             w_accept;
    logic             w_rd_en;
    logic             w_grant;
    logic             w_pop;
    logic             w_unused_base;
    logic [CNT_W-1:0] w_fifo_count;
    rd_entry_t        w_push_data;
    rd_entry_t        w_head;

    assign w_unused_base = ^i_base[1:0];
    assign w_accept      = (r_state == IDLE) && i_start;
    assign w_pop         = (w_fifo_count != {CNT_W{1'b0}}) && i_tready;

    // Credit check counts the read already in flight and frees the slot being
    // popped this cycle, which is what lets a 2-entry buffer sustain 1 word/cycle.
    assign w_occupancy = 32'(w_fifo_count) + {31'd0, r_inflight} - {31'd0, w_pop};
    assign w_rd_en     = (r_state == RUN) && (r_issue_cnt != {LEN_W{1'b0}})
                         && (w_occupancy < 32'(FIFO_DEPTH));
    assign w_grant     = w_rd_en && i_mem_gnt;
    assign w_addr_inc  = r_addr + 32'(WORD_BYTES);
    assign w_addr_nxt  = (w_addr_inc >= 32'(MEM_SIZE)) ? 32'd0 : w_addr_inc;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len != {LEN_W{1'b0}}) ? RUN : DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_grant && (r_issue_cnt == LEN_W'(1))) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if ((r_emit_cnt == {LEN_W{1'b0}}) || ((r_emit_cnt == LEN_W'(1)) && w_pop)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address, transfer counters and the one-deep inflight tracker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr          <= 32'd0;
            r_issue_cnt     <= {LEN_W{1'b0}};
            r_emit_cnt      <= {LEN_W{1'b0}};
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_grant;
            r_inflight_last <= w_grant && (r_issue_cnt == LEN_W'(1));
            if (w_accept && (i_len != {LEN_W{1'b0}})) begin
                r_addr      <= {i_base[31:2], 2'b00};
                r_issue_cnt <= i_len;
                r_emit_cnt  <= i_len;
            end else begin
                if (w_grant) begin
                    r_addr      <= w_addr_nxt;
                    r_issue_cnt <= r_issue_cnt - LEN_W'(1);
                end else begin
                    r_addr      <= r_addr;
                    r_issue_cnt <= r_issue_cnt;
                end
                if (w_pop) begin
                    r_emit_cnt <= r_emit_cnt - LEN_W'(1);
                end else begin
                    r_emit_cnt <= r_emit_cnt;
                end
            end
        end
    end

    assign w_push_data.last = r_inflight_last;
    assign w_push_data.data = i_mem_rdata;

    dmem_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (w_head)
    );

`ifdef DMEM_RD_CHECKSUM_EN
    logic [31:0] r_sum;

    // Running sum of handed-off words, cleared by each accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= 32'd0;
        end else if (w_accept) begin
            r_sum <= 32'd0;
        end else if (w_pop) begin
            r_sum <= r_sum + w_head.data;
        end else begin
            r_sum <= r_sum;
        end
    end

    assign o_sum = r_sum;
`endif

    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_mem_rd_en = w_rd_en;
    assign o_mem_addr  = r_addr;
    assign o_tvalid    = (w_fifo_count != {CNT_W{1'b0}});
    assign o_tdata     = w_head.data;
    assign o_tlast     = w_head.last;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Randomised and directed bench for dmem_stream_reader against a queue-based
// model of the memory region and the expected stream.
module tb_dmem_stream_reader;

    localparam int MEM_SIZE   = 1024;
    localparam int FIFO_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base;
    logic [15:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_mem_rd_en;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic [31:0] i_mem_rdata;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        i_tready;
`ifdef DMEM_RD_CHECKSUM_EN
    logic [31:0] o_sum;
`endif

    dmem_stream_reader #(
        .MEM_SIZE   (MEM_SIZE),
        .LEN_W      (16),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_rd_en (o_mem_rd_en),
        .o_mem_addr  (o_mem_addr),
        .i_mem_gnt   (i_mem_gnt),
        .i_mem_rdata (i_mem_rdata),
        .o_tvalid    (o_tvalid),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .i_tready    (i_tready)
`ifdef DMEM_RD_CHECKSUM_EN
        ,
        .o_sum       (o_sum)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [31:0] mem [256];

    // Behavioural model state (owned by the monitor)
    logic [31:0] exp_addr_q [$];
    logic [32:0] exp_data_q [$];
    logic [31:0] grant_log [$];
    int          hs_cyc [$];
    bit          m_busy;
    bit          m_done_now;
    logic [31:0] m_sum;
    int          grants;
    int          hs_total;
    int          n_denied;
    int          start_cyc;
    int          done_cyc;
    bit          mem_pending;
    logic [31:0] mem_pend_addr;

    // Driver knobs
    int          gnt_mode;
    int          tready_mode;
    int          stall;
    bit          gnt_ph;
    logic [31:0] lit [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_start = 1'b0;
        case (gnt_mode)
            0: i_mem_gnt = 1'b1;
            1: begin gnt_ph = !gnt_ph; i_mem_gnt = gnt_ph; end
            default: i_mem_gnt = ($urandom_range(0, 3) != 0);
        endcase
        case (tready_mode)
            0: i_tready = 1'b1;
            1: begin
                if (stall > 0) begin i_tready = 1'b0; stall--; end
                else i_tready = 1'b1;
            end
            default: i_tready = ($urandom_range(0, 3) != 0);
        endcase
        i_mem_rdata = mem_pending ? mem[mem_pend_addr[9:2]] : $urandom();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rd_en"}, o_mem_rd_en, 0);
        chk({tag, "_addr"}, o_mem_addr, 0);
        chk({tag, "_tvalid"}, o_tvalid, 0);
        chk({tag, "_tdata"}, o_tdata, 0);
        chk({tag, "_tlast"}, o_tlast, 0);
`ifdef DMEM_RD_CHECKSUM_EN
        chk({tag, "_sum"}, o_sum, 0);
`endif
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [15:0] len,
                            input int stall_n, input bit inject, input int budget);
        tick();
        i_start = 1'b1;
        i_base  = base;
        i_len   = len;
        stall   = stall_n;
        gnt_ph  = 1'b0;
        tick();
        for (int n = 0; n < budget && m_busy; n++) begin
            tick();
            if (inject && ($urandom_range(0, 7) == 0)) begin
                i_start = 1'b1;
                i_base  = $urandom_range(0, 1023);
                i_len   = 16'($urandom_range(0, 9));
            end
        end
        if (m_busy) begin
            chk("timeout_busy", 1, 0);
            rst = 1'b0;
            tick();
            rst = 1'b1;
        end
    endtask

    // Compare process: checks every cycle against the queue model, then advances it
    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] a;
        bit          last_hs;
        bit          acc;
        cyc++;
        if (!rst) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            m_busy      = 1'b0;
            m_done_now  = 1'b0;
            m_sum       = 32'd0;
            grants      = 0;
            hs_total    = 0;
            mem_pending = 1'b0;
        end else begin
            chk("busy", o_busy, m_busy);
            chk("done", o_done, m_done_now);
`ifdef DMEM_RD_CHECKSUM_EN
            chk("sum", o_sum, m_sum);
`endif
            if (!m_busy) begin
                chk("idle_rd_en", o_mem_rd_en, 0);
                chk("idle_tvalid", o_tvalid, 0);
            end else if (exp_addr_q.size() == 0) begin
                chk("rd_en_after_last", o_mem_rd_en, 0);
            end
            if (exp_data_q.size() == 0) chk("tvalid_no_data", o_tvalid, 0);

            mem_pending = 1'b0;
            if (o_mem_rd_en && exp_addr_q.size() != 0) begin
                chk("mem_addr", o_mem_addr, exp_addr_q[0]);
                if (i_mem_gnt) begin
                    mem_pending   = 1'b1;
                    mem_pend_addr = exp_addr_q[0];
                    grant_log.push_back(exp_addr_q[0]);
                    void'(exp_addr_q.pop_front());
                    grants++;
                end else begin
                    n_denied++;
                end
            end

            last_hs = 1'b0;
            if (o_tvalid && i_tready && exp_data_q.size() != 0) begin
                e = exp_data_q.pop_front();
                chk("tdata", o_tdata, e[31:0]);
                chk("tlast", o_tlast, e[32]);
                m_sum = m_sum + e[31:0];
                hs_total++;
                hs_cyc.push_back(cyc);
                last_hs = e[32];
            end
            if (m_busy) chk("outstanding_le_depth", (grants - hs_total) <= FIFO_DEPTH, 1);

            acc = i_start && !m_busy;
            if (m_done_now) begin
                m_done_now = 1'b0;
                m_busy     = 1'b0;
                done_cyc   = cyc;
            end
            if (last_hs) m_done_now = 1'b1;
            if (acc) begin
                m_busy    = 1'b1;
                start_cyc = cyc;
                m_sum     = 32'd0;
                n_denied  = 0;
                grant_log.delete();
                hs_cyc.delete();
                a = (i_base & 32'hFFFF_FFFC) % MEM_SIZE;
                for (int k = 0; k < int'(i_len); k++) begin
                    exp_addr_q.push_back(a);
                    exp_data_q.push_back({(k == int'(i_len) - 1), mem[a / 4]});
                    a = (a + 4) % MEM_SIZE;
                end
                if (i_len == 16'd0) m_done_now = 1'b1;
            end
        end
    end

    initial begin
        clk = 1'b0; rst = 1'b0; i_start = 1'b0; i_base = 32'd0; i_len = 16'd0;
        i_mem_gnt = 1'b0; i_mem_rdata = 32'd0; i_tready = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; n_denied = 0;
        gnt_mode = 0; tready_mode = 0; stall = 0; gnt_ph = 1'b0;
        start_cyc = 0; done_cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: base 0x10, len 4, full rate
        run_xfer(32'h10, 16'd4, 0, 1'b0, 100);
        lit[0] = 32'h10; lit[1] = 32'h14; lit[2] = 32'h18; lit[3] = 32'h1C;
        chk("t1_grant_count", grant_log.size(), 4);
        chk("t1_beat_count", hs_cyc.size(), 4);
        if (grant_log.size() == 4 && hs_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t1_addr", grant_log[k], lit[k]);
            // counted from the first busy cycle
            chk("t1_first_beat_latency", hs_cyc[0] - (start_cyc + 1), 2);
            chk("t1_back_to_back", hs_cyc[3] - hs_cyc[0], 3);
            chk("t1_done_after_last", done_cyc - hs_cyc[3], 1);
        end

        // 2: empty transfer
        run_xfer(32'h40, 16'd0, 0, 1'b0, 20);
        chk("t2_no_reads", grant_log.size(), 0);
        chk("t2_no_beats", hs_cyc.size(), 0);
        chk("t2_done_next", done_cyc - start_cyc, 1);

        // 3: wrap at the top of memory
        run_xfer(32'h3F8, 16'd4, 0, 1'b0, 100);
        lit[0] = 32'h3F8; lit[1] = 32'h3FC; lit[2] = 32'h000; lit[3] = 32'h004;
        chk("t3_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t3_addr", grant_log[k], lit[k]);
        end

        // 4: sink stalls 10 cycles, len 8
        tready_mode = 1;
        run_xfer(32'h200, 16'd8, 10, 1'b0, 200);
        chk("t4_beat_count", hs_cyc.size(), 8);
        if (hs_cyc.size() != 0) chk("t4_first_beat_after_stall", hs_cyc[0] - start_cyc, 11);
        chk("t4_reads_during_stall", grant_log.size(), 8);

        // 5: grant toggling, len 3
        tready_mode = 0; gnt_mode = 1;
        run_xfer(32'h81, 16'd3, 0, 1'b0, 100);
        lit[0] = 32'h80; lit[1] = 32'h84; lit[2] = 32'h88;
        chk("t5_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t5_addr", grant_log[k], lit[k]);
        end
        chk("t5_beat_count", hs_cyc.size(), 3);
        chk("t5_some_denied", n_denied > 0, 1);

        // 6: reset during beat 2 of len 6, then a clean transfer of 1,2,3
        gnt_mode = 0;
        tick();
        i_start = 1'b1; i_base = 32'h100; i_len = 16'd6;
        tick();
        for (int n = 0; n < 50 && hs_cyc.size() < 1; n++) tick();
        chk("t6_beat2_presented", o_tvalid, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("t6_async_reset");
        tick();
        rst = 1'b1;
        mem[128] = 32'd1; mem[129] = 32'd2; mem[130] = 32'd3;
        run_xfer(32'h200, 16'd3, 0, 1'b0, 100);
        chk("t6_beats_after_reset", hs_cyc.size(), 3);
`ifdef DMEM_RD_CHECKSUM_EN
        chk("t6_sum_literal", o_sum, 32'd6);
`endif

        // Random traffic with starts injected while busy
        gnt_mode = 2; tready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            run_xfer($urandom_range(0, 1023), 16'($urandom_range(0, 12)), 0, 1'b1, 400);
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
